// File: rtl/alu_reservation_station.sv
// ALU / branch-compare reservation station: buffers dispatched ops until both
// operands are known, issues the lowest-index ready entry and broadcasts its result.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module alu_reservation_station #(
   parameter int RS_SIZE_BIT  = 3,
   parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    clear,
   input  logic                    inst_valid,
   input  logic [3:0]              inst_op,
   input  logic [ROB_SIZE_BIT-1:0] inst_rob_id,
   input  logic                    inst_qj_valid,
   input  logic [ROB_SIZE_BIT-1:0] inst_qj,
   input  logic [31:0]             inst_vj,
   input  logic                    inst_qk_valid,
   input  logic [ROB_SIZE_BIT-1:0] inst_qk,
   input  logic [31:0]             inst_vk,
   input  logic                    lsb_is_set,
   input  logic [ROB_SIZE_BIT-1:0] lsb_set_id,
   input  logic [31:0]             lsb_set_val,
   output logic                    full,
   output logic                    rs_is_set,
   output logic [ROB_SIZE_BIT-1:0] rs_set_id,
   output logic [31:0]             rs_set_val
);
   localparam int RS_SIZE = 1 << RS_SIZE_BIT;

   typedef struct packed {
      logic                    busy;
      logic [3:0]              op;
      logic [ROB_SIZE_BIT-1:0] rob_id;
      logic                    qj_valid;
      logic [ROB_SIZE_BIT-1:0] qj;
      logic [31:0]             vj;
      logic                    qk_valid;
      logic [ROB_SIZE_BIT-1:0] qk;
      logic [31:0]             vk;
   } entry_t;

   entry_t                  ent_q [RS_SIZE];
   entry_t                  ent_d [RS_SIZE];
   logic                    rs_is_set_q, rs_is_set_d;
   logic [ROB_SIZE_BIT-1:0] rs_set_id_q, rs_set_id_d;
   logic [31:0]             rs_set_val_q, rs_set_val_d;

   logic                    sel_found, free_found;
   logic [RS_SIZE_BIT-1:0]  sel_idx, free_idx;

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] res;
      res = '0;
      case (op)
         4'd0:  res = a + b;
         4'd1:  res = a - b;
         4'd2:  res = a & b;
         4'd3:  res = a | b;
         4'd4:  res = a ^ b;
         4'd5:  res = a << b[4:0];
         4'd6:  res = a >> b[4:0];
         4'd7:  res = unsigned'($signed(a) >>> b[4:0]);
         4'd8:  res = {31'b0, $signed(a) < $signed(b)};
         4'd9:  res = {31'b0, a < b};
         4'd10: res = {31'b0, a == b};
         4'd11: res = {31'b0, a != b};
         4'd12: res = {31'b0, $signed(a) < $signed(b)};
         4'd13: res = {31'b0, $signed(a) >= $signed(b)};
         4'd14: res = {31'b0, a < b};
         4'd15: res = {31'b0, a >= b};
         default: res = '0;
      endcase
      return res;
   endfunction

   // Descending scans so the lowest matching index is the one that sticks.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (ent_q[i].busy && !ent_q[i].qj_valid && !ent_q[i].qk_valid) begin
            sel_found = 1'b1;
            sel_idx   = RS_SIZE_BIT'(i);
         end
         if (!ent_q[i].busy) begin
            free_found = 1'b1;
            free_idx   = RS_SIZE_BIT'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      ent_d        = ent_q;
      rs_is_set_d  = 1'b0;
      rs_set_id_d  = rs_set_id_q;
      rs_set_val_d = rs_set_val_q;

      // Wakeup: the LSB check comes second so it wins when both broadcasts match.
      for (int i = 0; i < RS_SIZE; i++) begin
         if (ent_q[i].busy && ent_q[i].qj_valid) begin
            if (rs_is_set_q && ent_q[i].qj == rs_set_id_q) begin
               ent_d[i].qj_valid = 1'b0;
               ent_d[i].vj       = rs_set_val_q;
            end
            if (lsb_is_set && ent_q[i].qj == lsb_set_id) begin
               ent_d[i].qj_valid = 1'b0;
               ent_d[i].vj       = lsb_set_val;
            end
         end
         if (ent_q[i].busy && ent_q[i].qk_valid) begin
            if (rs_is_set_q && ent_q[i].qk == rs_set_id_q) begin
               ent_d[i].qk_valid = 1'b0;
               ent_d[i].vk       = rs_set_val_q;
            end
            if (lsb_is_set && ent_q[i].qk == lsb_set_id) begin
               ent_d[i].qk_valid = 1'b0;
               ent_d[i].vk       = lsb_set_val;
            end
         end
      end

      if (sel_found) begin
         ent_d[sel_idx].busy = 1'b0;
         rs_is_set_d         = 1'b1;
         rs_set_id_d         = ent_q[sel_idx].rob_id;
         rs_set_val_d        = alu(ent_q[sel_idx].op, ent_q[sel_idx].vj, ent_q[sel_idx].vk);
      end

      if (inst_valid && free_found) begin
         ent_d[free_idx] = '{busy: 1'b1, op: inst_op, rob_id: inst_rob_id,
                             qj_valid: inst_qj_valid, qj: inst_qj, vj: inst_vj,
                             qk_valid: inst_qk_valid, qk: inst_qk, vk: inst_vk};
         if (inst_qj_valid && rs_is_set_q && inst_qj == rs_set_id_q) begin
            ent_d[free_idx].qj_valid = 1'b0;
            ent_d[free_idx].vj       = rs_set_val_q;
         end
         if (inst_qj_valid && lsb_is_set && inst_qj == lsb_set_id) begin
            ent_d[free_idx].qj_valid = 1'b0;
            ent_d[free_idx].vj       = lsb_set_val;
         end
         if (inst_qk_valid && rs_is_set_q && inst_qk == rs_set_id_q) begin
            ent_d[free_idx].qk_valid = 1'b0;
            ent_d[free_idx].vk       = rs_set_val_q;
         end
         if (inst_qk_valid && lsb_is_set && inst_qk == lsb_set_id) begin
            ent_d[free_idx].qk_valid = 1'b0;
            ent_d[free_idx].vk       = lsb_set_val;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         // NOTE: the entry array is plain flops, so it is reset wholesale; clear drops busy only.
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         rs_is_set_q  <= 1'b0;
         rs_set_id_q  <= '0;
         rs_set_val_q <= '0;
      end else if (rdy_in) begin
         if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
            rs_is_set_q <= 1'b0;
         end else begin
            ent_q        <= ent_d;
            rs_is_set_q  <= rs_is_set_d;
            rs_set_id_q  <= rs_set_id_d;
            rs_set_val_q <= rs_set_val_d;
         end
      end
   end

   assign full       = ~free_found;
   assign rs_is_set  = rs_is_set_q;
   assign rs_set_id  = rs_set_id_q;
   assign rs_set_val = rs_set_val_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed + random bench for alu_reservation_station against a slot-array
// reference model; every step compares full and the broadcast bus.
module tb_alu_reservation_station;
   localparam int RB = 4;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, clear, inst_valid;
   logic [3:0]    inst_op;
   logic [RB-1:0] inst_rob_id, inst_qj, inst_qk, lsb_set_id;
   logic          inst_qj_valid, inst_qk_valid, lsb_is_set;
   logic [31:0]   inst_vj, inst_vk, lsb_set_val;
   logic          full, rs_is_set;
   logic [RB-1:0] rs_set_id;
   logic [31:0]   rs_set_val;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   alu_reservation_station #(.RS_SIZE_BIT(3), .ROB_SIZE_BIT(RB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .inst_valid(inst_valid), .inst_op(inst_op), .inst_rob_id(inst_rob_id),
      .inst_qj_valid(inst_qj_valid), .inst_qj(inst_qj), .inst_vj(inst_vj),
      .inst_qk_valid(inst_qk_valid), .inst_qk(inst_qk), .inst_vk(inst_vk),
      .lsb_is_set(lsb_is_set), .lsb_set_id(lsb_set_id), .lsb_set_val(lsb_set_val),
      .full(full), .rs_is_set(rs_is_set), .rs_set_id(rs_set_id), .rs_set_val(rs_set_val)
   );

   // Reference model: eight slots plus the broadcast bus.
   typedef struct {
      bit            busy;
      logic [3:0]    op;
      logic [RB-1:0] rob;
      bit            jp;
      logic [RB-1:0] qj;
      logic [31:0]   vj;
      bit            kp;
      logic [RB-1:0] qk;
      logic [31:0]   vk;
   } slot_t;

   slot_t         m [8];
   bit            m_bc;
   logic [RB-1:0] m_id;
   logic [31:0]   m_val;

   function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] s;
      logic [31:0] t;
      int          sh;
      s  = a ^ 32'h8000_0000;
      t  = b ^ 32'h8000_0000;
      sh = int'(b[4:0]);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a + ~b + 32'd1;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd8:  return (s < t) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return (a == b) ? 32'd1 : 32'd0;
         4'd11: return (a != b) ? 32'd1 : 32'd0;
         4'd12: return (s < t) ? 32'd1 : 32'd0;
         4'd13: return (s >= t) ? 32'd1 : 32'd0;
         4'd14: return (a < b) ? 32'd1 : 32'd0;
         default: return (a >= b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic bit m_full();
      for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      m_bc  = 1'b0;
      m_id  = '0;
      m_val = '0;
   endtask

   // Resolve one pending operand against the current bus values; LSB has the last word.
   task automatic snoop(inout bit p, inout logic [31:0] v, input logic [RB-1:0] tag);
      bit was_p;
      was_p = p;
      if (was_p && m_bc && tag == m_id) begin
         p = 1'b0;
         v = m_val;
      end
      if (was_p && lsb_is_set && tag == lsb_set_id) begin
         p = 1'b0;
         v = lsb_set_val;
      end
   endtask

   task automatic model_edge();
      slot_t         nx [8];
      int            sel, fr;
      bit            p;
      logic [31:0]   v;
      if (rst_in) begin
         model_reset();
         return;
      end
      if (!rdy_in) return;
      if (clear) begin
         for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
         m_bc = 1'b0;
         return;
      end
      nx  = m;
      sel = -1;
      fr  = -1;
      for (int i = 0; i < 8; i++) begin
         if (sel < 0 && m[i].busy && !m[i].jp && !m[i].kp) sel = i;
         if (fr < 0 && !m[i].busy) fr = i;
      end
      for (int i = 0; i < 8; i++) begin
         if (m[i].busy) begin
            p = nx[i].jp; v = nx[i].vj; snoop(p, v, nx[i].qj); nx[i].jp = p; nx[i].vj = v;
            p = nx[i].kp; v = nx[i].vk; snoop(p, v, nx[i].qk); nx[i].kp = p; nx[i].vk = v;
         end
      end
      if (inst_valid && fr >= 0) begin
         nx[fr] = '{1'b1, inst_op, inst_rob_id, inst_qj_valid, inst_qj, inst_vj,
                    inst_qk_valid, inst_qk, inst_vk};
         p = nx[fr].jp; v = nx[fr].vj; snoop(p, v, nx[fr].qj); nx[fr].jp = p; nx[fr].vj = v;
         p = nx[fr].kp; v = nx[fr].vk; snoop(p, v, nx[fr].qk); nx[fr].kp = p; nx[fr].vk = v;
      end
      if (sel >= 0) begin
         nx[sel].busy = 1'b0;
         m_bc  = 1'b1;
         m_id  = m[sel].rob;
         m_val = ref_alu(m[sel].op, m[sel].vj, m[sel].vk);
      end else begin
         m_bc = 1'b0;
      end
      m = nx;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic dispatch(logic [3:0] op, logic [RB-1:0] rob, bit jp, logic [RB-1:0] qj,
                           logic [31:0] vj, bit kp, logic [RB-1:0] qk, logic [31:0] vk);
      inst_valid    = 1'b1;
      inst_op       = op;
      inst_rob_id   = rob;
      inst_qj_valid = jp;
      inst_qj       = qj;
      inst_vj       = vj;
      inst_qk_valid = kp;
      inst_qk       = qk;
      inst_vk       = vk;
   endtask

   task automatic lsb(logic [RB-1:0] id, logic [31:0] val);
      lsb_is_set  = 1'b1;
      lsb_set_id  = id;
      lsb_set_val = val;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk_in);
      #1;
      check("full", full, m_full());
      check("rs_is_set", rs_is_set, m_bc);
      check("rs_set_id", rs_set_id, m_id);
      check("rs_set_val", rs_set_val, m_val);
      inst_valid = 1'b0;
      lsb_is_set = 1'b0;
      clear      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; inst_valid = 1'b0;
      inst_op = '0; inst_rob_id = '0; inst_qj_valid = 1'b0; inst_qj = '0; inst_vj = '0;
      inst_qk_valid = 1'b0; inst_qk = '0; inst_vk = '0;
      lsb_is_set = 1'b0; lsb_set_id = '0; lsb_set_val = '0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_is_set", rs_is_set, 0);
      check("reset_id", rs_set_id, 0);
      check("reset_val", rs_set_val, 0);
      check("reset_full", full, 0);
      rst_in = 1'b0;

      // ADD 5+7 -> rob 3, one cycle after dispatch
      dispatch(4'd0, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
      step();
      step();
      check("add_valid", rs_is_set, 1);
      check("add_id", rs_set_id, 3);
      check("add_val", rs_set_val, 12);
      step();
      check("add_gone", rs_is_set, 0);

      // SUB pending on tag 5, woken by a later LSB broadcast
      dispatch(4'd1, 4'd4, 1, 4'd5, 32'd0, 0, 0, 32'd1);
      step();
      step();
      lsb(4'd5, 32'd100);
      step();
      step();
      check("sub_valid", rs_is_set, 1);
      check("sub_id", rs_set_id, 4);
      check("sub_val", rs_set_val, 99);
      step();

      // Same SUB with the LSB broadcast in the dispatch cycle
      dispatch(4'd1, 4'd4, 1, 4'd5, 32'd0, 0, 0, 32'd1);
      lsb(4'd5, 32'd100);
      step();
      step();
      check("bypass_valid", rs_is_set, 1);
      check("bypass_val", rs_set_val, 99);
      step();

      // Dependency chain through the own broadcast
      dispatch(4'd0, 4'd1, 0, 0, 32'd2, 0, 0, 32'd3);
      step();
      dispatch(4'd5, 4'd2, 1, 4'd1, 32'd0, 0, 0, 32'd4);
      step();
      check("chain_p_id", rs_set_id, 1);
      check("chain_p_val", rs_set_val, 5);
      step();
      check("chain_gap", rs_is_set, 0);
      step();
      check("chain_c_id", rs_set_id, 2);
      check("chain_c_val", rs_set_val, 80);
      step();

      dispatch(4'd7, 4'd6, 0, 0, 32'h8000_0000, 0, 0, 32'd4);
      step();
      dispatch(4'd14, 4'd7, 0, 0, 32'd1, 0, 0, 32'hFFFF_FFFF);
      step();
      check("sra_val", rs_set_val, 32'hF800_0000);
      step();
      check("bltu_val", rs_set_val, 1);
      step();

      // Fill all entries pending on tag 9, drop a 9th, then drain in order
      for (int i = 0; i < 8; i++) begin
         dispatch(4'd0, RB'(i), 1, 4'd9, 32'd0, 0, 0, 32'(i));
         step();
      end
      check("fill_full", full, 1);
      dispatch(4'd0, 4'd8, 0, 0, 32'd1, 0, 0, 32'd1);
      step();
      check("drop_full", full, 1);
      lsb(4'd9, 32'd10);
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         check("drain_id", rs_set_id, 32'(i));
         check("drain_val", rs_set_val, 32'(10 + i));
         if (i == 0) check("drain_full", full, 0);
      end
      step();
      check("drain_end", rs_is_set, 0);

      // Pause during an active broadcast
      dispatch(4'd0, 4'd5, 0, 0, 32'd1, 0, 0, 32'd1);
      step();
      step();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lsb(4'd3, 32'd4);
         step();
         check("hold_valid", rs_is_set, 1);
         check("hold_id", rs_set_id, 5);
         check("hold_val", rs_set_val, 2);
      end
      rdy_in = 1'b1;
      step();

      // Flush with four busy entries; a same-cycle dispatch is ignored
      for (int i = 0; i < 4; i++) begin
         dispatch(4'd0, RB'(10 + i), 1, 4'd12, 32'd0, 0, 0, 32'd1);
         step();
      end
      clear = 1'b1;
      dispatch(4'd0, 4'd14, 0, 0, 32'd1, 0, 0, 32'd1);
      step();
      check("clear_full", full, 0);
      check("clear_valid", rs_is_set, 0);
      lsb(4'd12, 32'd1);
      step();
      step();
      check("clear_quiet", rs_is_set, 0);
      dispatch(4'd0, 4'd1, 1, 4'd13, 32'd0, 0, 0, 32'd1);
      step();
      dispatch(4'd0, 4'd2, 1, 4'd13, 32'd0, 0, 0, 32'd2);
      step();
      lsb(4'd13, 32'd3);
      step();
      step();
      check("post_clear_first", rs_set_id, 1);
      step();
      check("post_clear_second", rs_set_id, 2);
      step();

      // Asynchronous reset between edges
      for (int i = 0; i < 3; i++) begin
         dispatch(4'd0, RB'(i + 1), 1, 4'd15, 32'd0, 0, 0, 32'd1);
         step();
      end
      #3;
      rst_in = 1'b1;
      #1;
      check("async_rst_valid", rs_is_set, 0);
      check("async_rst_full", full, 0);
      model_reset();
      step();
      rst_in = 1'b0;
      lsb(4'd15, 32'd7);
      step();
      step();
      check("async_rst_quiet", rs_is_set, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) != 0)
            dispatch(4'($urandom_range(0, 15)), RB'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), RB'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), RB'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 2) == 0) lsb(RB'($urandom_range(0, 7)), $urandom);
         clear = ($urandom_range(0, 99) == 0);
         step();
      end
      rdy_in = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
